// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter for one SRAM port, with a timeout that returns an error response
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [7:0]  lsu_wmask,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic owner, last_grant, wen_q, err_q, grant_ifu, grant_lsu, tmo;
  logic [7:0] wmask_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    grant_ifu = rst && state == IDLE && ifu_req_valid && (!lsu_req_valid || last_grant);
    grant_lsu = rst && state == IDLE && lsu_req_valid && (!ifu_req_valid || !last_grant);
    tmo = cnt == CNT_W'(TIMEOUT - 1);
    state_n = state == IDLE ? ((grant_ifu || grant_lsu) ? BUSY : IDLE) :
              state == BUSY ? ((mem_valid || tmo) ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner <= 1'b0;
      last_grant <= 1'b1;
      addr_q <= '0;
      wen_q <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (grant_ifu || grant_lsu) begin
        owner <= grant_lsu;
        last_grant <= grant_lsu;
        addr_q <= grant_lsu ? lsu_addr : ifu_addr;
        wen_q <= grant_lsu && lsu_wen;
        wmask_q <= grant_lsu ? lsu_wmask : '0;
        wdata_q <= grant_lsu ? lsu_wdata : '0;
        cnt <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        rdata_q <= (mem_valid && !wen_q) ? mem_rdata : '0;
        err_q <= !mem_valid;
      end
    end
  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign mem_ren = state == BUSY && !wen_q;
  assign mem_wen = state == BUSY && wen_q;
  assign mem_addr = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign ifu_resp_valid = state == RESP && !owner;
  assign lsu_resp_valid = state == RESP && owner;
  assign ifu_rdata = ifu_resp_valid ? rdata_q : '0;
  assign lsu_rdata = lsu_resp_valid ? rdata_q : '0;
  assign resp_err = state == RESP && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;
  localparam int T = 4;
  logic clk = 0, rst = 0;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, resp_err;
  logic [7:0] lsu_wmask, mem_wmask;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic mem_ren, mem_wen, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  typedef struct {bit owner; int unsigned gap; logic wen; logic [7:0] mask; logic [31:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {bit owner; logic [31:0] rdata; logic err; longint cyc;} exp_t;
  typedef struct {int d; logic [31:0] data;} dly_t;
  req_t ifu_q[$], lsu_q[$], cmd_q[$];
  exp_t exp_q[$];
  dly_t dly_q[$];
  bit grant_log[$];
  bit ifu_busy, lsu_busy, resp_busy, skip, last_g = 1;
  longint cyc;
  int checks, errors;
  mem_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_wmask(lsu_wmask), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none (t=%0t)", name, $time);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((ifu_q.size() || lsu_q.size() || ifu_busy || lsu_busy || cmd_q.size() || exp_q.size() || resp_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("wait_idle");
    repeat (2) @(negedge clk);
  endtask
  initial begin
    req_t r;
    int n;
    bit acc;
    ifu_req_valid = 0;
    ifu_addr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ifu_q.size()) begin
        r = ifu_q.pop_front();
        ifu_busy = 1;
        if (r.gap > 0) begin
          repeat (r.gap) @(posedge clk);
          #1;
        end
        ifu_req_valid = 1;
        ifu_addr = r.addr;
        n = 0;
        do begin
          @(negedge clk);
          acc = rst && ifu_req_ready;
          n++;
        end while (!acc && n < 500);
        if (!acc) fail("ifu_accept_timeout");
        @(posedge clk);
        #1;
        ifu_req_valid = 0;
        ifu_addr = $urandom;
        ifu_busy = 0;
      end
    end
  end
  initial begin
    req_t r;
    int n;
    bit acc;
    lsu_req_valid = 0;
    lsu_wen = 0;
    lsu_wmask = 0;
    lsu_addr = 0;
    lsu_wdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (lsu_q.size()) begin
        r = lsu_q.pop_front();
        lsu_busy = 1;
        if (r.gap > 0) begin
          repeat (r.gap) @(posedge clk);
          #1;
        end
        lsu_req_valid = 1;
        {lsu_wen, lsu_wmask, lsu_addr, lsu_wdata} = {r.wen, r.mask, r.addr, r.wdata};
        n = 0;
        do begin
          @(negedge clk);
          acc = rst && lsu_req_ready;
          n++;
        end while (!acc && n < 500);
        if (!acc) fail("lsu_accept_timeout");
        @(posedge clk);
        #1;
        lsu_req_valid = 0;
        {lsu_wen, lsu_wmask, lsu_addr, lsu_wdata} = {1'b0, 8'($urandom), 32'($urandom), 32'($urandom)};
        lsu_busy = 0;
      end
    end
  end
  always @(negedge clk) begin
    req_t c;
    exp_t e;
    bit g;
    if (!rst) last_g = 1;
    else begin
      if (ifu_req_ready && lsu_req_ready) fail("double_ready");
      if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
        g = lsu_req_ready;
        if (ifu_req_valid && lsu_req_valid) chk("rr_grant", g, !last_g);
        last_g = g;
        grant_log.push_back(g);
        c.owner = g;
        c.gap = 0;
        c.wen = g ? lsu_wen : 1'b0;
        c.mask = g ? lsu_wmask : 8'h0;
        c.addr = g ? lsu_addr : ifu_addr;
        c.wdata = g ? lsu_wdata : 32'h0;
        cmd_q.push_back(c);
      end
      if (ifu_resp_valid || lsu_resp_valid) begin
        if (exp_q.size() == 0) fail("spurious_resp");
        else begin
          e = exp_q.pop_front();
          chk("resp_valids", {ifu_resp_valid, lsu_resp_valid}, e.owner ? 2'b01 : 2'b10);
          chk("resp_rdata", e.owner ? lsu_rdata : ifu_rdata, e.rdata);
          chk("other_rdata", e.owner ? ifu_rdata : lsu_rdata, 0);
          chk("resp_err", resp_err, e.err);
          chk("resp_cycle", cyc, e.cyc);
          chk("mem_idle_in_resp", {mem_ren, mem_wen}, 0);
        end
      end
    end
  end
  initial begin
    req_t c;
    dly_t dl;
    exp_t e;
    int n;
    mem_valid = 0;
    mem_rdata = $urandom;
    forever begin
      @(negedge clk);
      if (rst && (mem_ren || mem_wen)) begin
        resp_busy = 1;
        if (cmd_q.size() == 0) begin
          fail("cmd_missing");
          c = '{default: 0};
        end else c = cmd_q.pop_front();
        if (skip) begin
          n = 0;
          while ((mem_ren || mem_wen) && n < 1000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          if (dly_q.size()) dl = dly_q.pop_front();
          else begin
            dl.d = $urandom_range(0, T);
            dl.data = $urandom;
          end
          chk("mem_cmd", {mem_ren, mem_wen, mem_addr, mem_wmask, c.wen ? mem_wdata : 32'h0},
              {!c.wen, c.wen, c.addr, c.mask, c.wen ? c.wdata : 32'h0});
          e.owner = c.owner;
          e.err = dl.d >= T;
          e.rdata = (dl.d < T && !c.wen) ? dl.data : 32'h0;
          e.cyc = cyc + ((dl.d < T) ? dl.d : T - 1) + 1;
          exp_q.push_back(e);
          for (int k = 1; k <= dl.d; k++) begin
            @(negedge clk);
            if (k < T) chk("mem_hold", {mem_ren, mem_wen, mem_addr}, {!c.wen, c.wen, c.addr});
          end
          mem_valid = 1;
          mem_rdata = dl.data;
          @(negedge clk);
          mem_valid = 0;
          mem_rdata = $urandom;
        end
        resp_busy = 0;
      end
    end
  end
  initial begin
    req_t r;
    int n;
    repeat (2) @(negedge clk);
    chk("reset_outputs", |{ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
                           resp_err, mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata}, 0);
    rst = 1;
    @(negedge clk);
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      ifu_q.push_back('{0, 0, 0, 8'h0, 32'h80000000 + 32'(i * 4), 32'h0});
      lsu_q.push_back('{1, 0, 0, 8'hff, 32'h80002000 + 32'(i * 4), 32'h0});
    end
    wait_idle();
    chk("tie_count", grant_log.size(), 4);
    if (grant_log.size() == 4) chk("tie_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
    dly_q.push_back('{2, 32'h00000413});
    ifu_q.push_back('{0, 0, 0, 8'h0, 32'h80000000, 32'h0});
    wait_idle();
    dly_q.push_back('{1, 32'hcafef00d});
    lsu_q.push_back('{1, 0, 1, 8'h0f, 32'h80001000, 32'hdeadbeef});
    wait_idle();
    dly_q.push_back('{T, 32'h55aa55aa});
    lsu_q.push_back('{1, 0, 0, 8'h00, 32'h80003000, 32'h0});
    dly_q.push_back('{T - 1, 32'h12345678});
    ifu_q.push_back('{0, 0, 0, 8'h0, 32'h80000010, 32'h0});
    wait_idle();
    for (int i = 0; i < 30; i++) begin
      r = '{0, $urandom_range(0, 3), 0, 8'h0, 32'($urandom), 32'h0};
      ifu_q.push_back(r);
      r = '{1, $urandom_range(0, 3), 1'($urandom), 8'($urandom), 32'($urandom), 32'($urandom)};
      lsu_q.push_back(r);
    end
    wait_idle();
    skip = 1;
    ifu_q.push_back('{0, 0, 0, 8'h0, 32'h80000020, 32'h0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ren && n < 200);
    if (!mem_ren) fail("busy_before_reset");
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("async_reset_outputs", |{ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
                                 resp_err, mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    n = 0;
    while ((resp_busy || ifu_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    skip = 0;
    grant_log.delete();
    ifu_q.push_back('{0, 0, 0, 8'h0, 32'h80000030, 32'h0});
    lsu_q.push_back('{1, 0, 0, 8'h0, 32'h80004000, 32'h0});
    wait_idle();
    chk("post_reset_first_grant", grant_log.size() > 0 ? grant_log[0] : 1'b1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SRAM port between the instruction fetch unit (IFU) and the load/store unit (LSU) in the npc core.
- Accepts one request at a time from either side over a valid/ready handshake and holds the SRAM command until the SRAM reports completion.
- Routes the read data or write acknowledgement back to the requester that owns the transaction.
- Guards against a hung SRAM with a timeout counter that returns an error response.

Parameters:
TIMEOUT, 64, cycles in BUSY without mem_valid before the transaction is aborted with an error; legal range 2..255
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
ifu_req_valid  input  1  IFU request valid; always a read
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_addr  input  32  IFU fetch address
ifu_resp_valid  output  1  one-cycle pulse, IFU response valid
ifu_rdata  output  32  IFU read data, valid with ifu_resp_valid
lsu_req_valid  input  1  LSU request valid
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_wen  input  1  1 = store, 0 = load
lsu_wmask  input  8  store byte mask
lsu_addr  input  32  LSU address
lsu_wdata  input  32  store data
lsu_resp_valid  output  1  one-cycle pulse, LSU response valid (load data or store ack)
lsu_rdata  output  32  load data, valid with lsu_resp_valid; 0 for stores
resp_err  output  1  qualifies whichever resp_valid is high; 1 = timeout abort
mem_ren  output  1  SRAM read enable
mem_wen  output  1  SRAM write enable
mem_wmask  output  8  SRAM write mask
mem_addr  output  32  SRAM address
mem_wdata  output  32  SRAM write data
mem_rdata  input  32  SRAM read data
mem_valid  input  1  SRAM completion, sampled in BUSY

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=LSU, counter=0. All outputs are 0, including the registered address, data and mask. Any in-flight transaction is dropped and no response is issued.
- States: IDLE, BUSY, RESP.
- IDLE arbitration:
  - ready outputs are combinational and asserted only in IDLE.
  - Only one valid: that requester gets ready=1.
  - Both valid: round-robin. The requester not equal to last_grant wins, so first contention after reset goes to IFU.
  - On handshake (valid&&ready): latch owner, addr, wen (forced 0 for IFU), wmask (0 for IFU) and wdata; set last_grant=owner; counter=0; go to BUSY.
  - The loser's ready stays 0. It must hold valid and its payload stable until accepted.
- BUSY:
  - mem_ren=!wen_latched and mem_wen=wen_latched, held continuously. mem_addr, mem_wmask and mem_wdata are driven from the latches; the inputs are never passed through.
  - mem_valid=1: capture mem_rdata (loads) or 0 (stores) into the response register, resp_err=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without mem_valid, go to RESP with rdata=0 and resp_err=1.
  - mem_valid in the same cycle as the timeout boundary takes priority: normal completion.
  - mem_valid outside BUSY is ignored.
- RESP:
  - Exactly one cycle. The owner's resp_valid=1 with the registered rdata and resp_err. Then go to IDLE; mem_ren and mem_wen are 0.
  - No new request is accepted in RESP.
  - Minimum turnaround per transaction is 3 cycles: accept, BUSY with immediate mem_valid, RESP.
- The non-owner's resp_valid and rdata are always 0.
- Back-to-back: a requester may present its next request in the cycle of its resp_valid. It is considered in the following IDLE cycle.

Test Plan:
1. Reset release, IFU read of 0x80000000, SRAM returns 0x00000413 after 3 BUSY cycles -> ifu_req_ready high in accept cycle; mem_ren high 3 cycles; ifu_resp_valid one pulse with 0x00000413; resp_err=0; lsu_resp_valid never high.
2. IFU and LSU both valid from reset -> IFU granted first. LSU is accepted in the next IDLE after IFU's RESP. A repeated simultaneous pair then alternates IFU, LSU, IFU, LSU.
3. LSU store addr 0x80001000, wdata 0xdeadbeef, wmask 0x0f, mem_valid after 1 cycle -> mem_wen=1, mem_ren=0, mask and data match; lsu_resp_valid pulse with lsu_rdata=0.
4. TIMEOUT=4, LSU load, mem_valid never asserted -> after 4 BUSY cycles lsu_resp_valid=1, resp_err=1, lsu_rdata=0; FSM back in IDLE and accepts a new IFU request.
5. Timeout edge: mem_valid asserted on the final BUSY cycle with data 0x12345678 -> normal response 0x12345678, resp_err=0.
6. Reset pulled low mid-BUSY -> all outputs 0 immediately (asynchronous). No resp_valid after release; the next request is arbitrated as the first after reset (IFU wins a tie).
